seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Iterative restoring divider, the inverse of the team's 8-bit multipliers: computes quotient and remainder of A / B. Supports unsigned and two's-complement signed modes, and reports divide-by-zero and signed overflow on O. Uses one quotient bit per clock and a start/busy/done handshake. Sits beside the multiplier in the arithmetic unit.

Parameters:
WIDTH, 8, operand/result width in bits (all arithmetic rules below are stated for WIDTH; tests use 8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while idle
is_signed  input  1  1 = two's-complement operands/results, 0 = unsigned; captured with start
A  input  WIDTH  dividend; captured with start
B  input  WIDTH  divisor; captured with start
Q  output  WIDTH  quotient, registered
R  output  WIDTH  remainder, registered
O  output  1  overflow/error flag, registered
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse; Q/R/O valid from this cycle

Behaviour:
- Single clock (clk). Reset is asynchronous, active-high: while reset=1 and immediately on its assertion, Q=0, R=0, O=0, busy=0, done=0, state=IDLE, iteration counter=0. Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, CALC, FIX.
  - IDLE: on an edge with start=1, capture A, B and is_signed, then go to CALC, counter=0, busy=1.
    - Signed mode: convert operands to magnitudes; record quotient sign = sign(A) XOR sign(B) and remainder sign = sign(A).
  - CALC: one restoring step per edge.
    - Shift {rem, dvd} left by 1.
    - Trial-subtract the divisor magnitude from rem (WIDTH+1 bits).
    - If non-negative, keep the difference and set quotient bit = 1; otherwise restore and set bit = 0.
    - After WIDTH steps (counter = WIDTH-1 on the edge), go to FIX.
  - FIX: apply signs, then write Q, R and O; done=1, busy=0, next state IDLE.
- Latency: if start is sampled at edge k, busy=1 after edge k, iterations occur at edges k+1..k+WIDTH, and Q/R/O/done update at edge k+WIDTH+1. done is high for exactly one cycle. For WIDTH=8, done rises 9 edges after the start edge.
- Q/R/O hold their values until the next FIX or reset. They do not change during CALC.
- start while busy=1 is ignored; captured operands are unaffected. start in the cycle done=1 is accepted (state is IDLE), giving back-to-back operation with no dead cycle.
- Changes on A/B/is_signed after the start edge have no effect.
- Unsigned: Q = floor(A/B), R = A mod B, O=0.
- Signed: the quotient truncates toward zero. R takes the sign of the dividend, with |R| < |B| and A = Q*B + R. O=0.
- Divide by zero (B=0, either mode): Q = all ones, R = A unchanged, O=1. Full latency still applies.
- Signed overflow (is_signed=1, A = most-negative, B = all ones, i.e. -1): Q = most-negative (8'h80), R=0, O=1.
- Most-negative dividend with any other divisor is valid. Its magnitude 2^(WIDTH-1) must be handled without loss (unsigned WIDTH-bit magnitude).

Test Plan:
- Unsigned: A=8'hC8 (200), B=8'h3F (63), start one cycle -> done exactly 9 edges later; Q=8'h03, R=8'h0B, O=0; busy high for the 9 intervening cycles.
- Signed: A=8'hF8 (-8), B=8'hFA (-6) -> Q=8'h01, R=8'hFE. Then, back-to-back with start in the done cycle, A=8'hCE (-50), B=8'h03 -> Q=8'hF0 (-16), R=8'hFE (-2), O=0.
- Divide by zero: unsigned A=8'h0F, B=8'h00 -> Q=8'hFF, R=8'h0F, O=1. Signed A=8'hF6, B=8'h00 -> Q=8'hFF, R=8'hF6, O=1.
- Signed overflow: A=8'h80, B=8'hFF -> Q=8'h80, R=8'h00, O=1. Also A=8'h80, B=8'h02 signed -> Q=8'hC0, R=8'h00, O=0.
- Handshake: start with A=8'hFF, B=8'h10 unsigned; re-assert start with A=8'h01, B=8'h01 at cycle 3 -> ignored; result is Q=8'h0F, R=8'h0F, with a single done pulse.
- Reset: assert reset at cycle 4 of an operation -> Q, R, O, busy, done go to 0 immediately (asynchronously); no done pulse follows. A fresh start after reset release yields correct results.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_divider: iterative restoring divider, one quotient bit per clock,      |
// | unsigned/signed modes with divide-by-zero and signed-overflow flag on O.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             O,
  output logic             busy,
  output logic             done
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             sgn_q, sgn_d;
  logic             o_q, o_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             q_neg, r_neg;

  // Magnitudes stay unsigned WIDTH bits so the most-negative value maps to 2^(WIDTH-1).
  assign a_mag   = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
  assign b_mag   = (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
  assign q_neg   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg   = sgn_q & a_q[WIDTH-1];
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, b_mag};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    q_d     = q_q;
    r_d     = r_q;
    o_d     = o_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = is_signed;
          dvd_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (b_q == '0) begin
          q_d = ONES;
          r_d = a_q;
          o_d = 1'b1;
        end else if (sgn_q && (a_q == MIN) && (b_q == ONES)) begin
          q_d = MIN;
          r_d = '0;
          o_d = 1'b1;
        end else begin
          q_d = q_neg ? (~dvd_q + 1'b1) : dvd_q;
          r_d = r_neg ? (~rem_q + 1'b1) : rem_q;
          o_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      o_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      q_q     <= q_d;
      r_q     <= r_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign O    = o_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_divider: scoreboard bench for seq_divider with an arithmetic model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         O;
  logic         busy;
  logic         done;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .R         (R),
    .O         (O),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         o;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           pe = 0;
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;
  logic         hold_o = 1'b0;

  always @(posedge clk) pe = pe + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division; SV int '/' and '%' truncate toward zero.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    int   sa, sb_, qi, ri;
    e.due = 0;
    if (b == 0) begin
      e.q = 8'hFF; e.r = a; e.o = 1'b1;
    end else if (!s) begin
      e.q = W'(int'(a) / int'(b)); e.r = W'(int'(a) % int'(b)); e.o = 1'b0;
    end else begin
      sa  = int'($signed(a));
      sb_ = int'($signed(b));
      if (sa == -128 && sb_ == -1) begin
        e.q = 8'h80; e.r = 8'h00; e.o = 1'b1;
      end else begin
        qi = sa / sb_;
        ri = sa % sb_;
        e.q = W'(qi); e.r = W'(ri); e.o = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: expected busy window, done pops the scoreboard, outputs hold otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0)
        chk("busy", 32'(busy), 32'((pe >= sb[0].due - 9) && (pe < sb[0].due)));
      else
        chk("busy_idle", 32'(busy), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("Q", 32'(Q), 32'(e.q));
          chk("R", 32'(R), 32'(e.r));
          chk("O", 32'(O), 32'(e.o));
          chk("latency", 32'(pe), 32'(e.due));
          hold_q = e.q; hold_r = e.r; hold_o = e.o;
        end
      end else begin
        chk("hold_Q", 32'(Q), 32'(hold_q));
        chk("hold_R", 32'(R), 32'(hold_r));
        chk("hold_O", 32'(O), 32'(hold_o));
      end
    end
  end

  // Called at posedge+1; the next posedge is the start edge, done is due 9 edges after it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    e = model(a, b, s);
    e.due = pe + 10;
    sb.push_back(e);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk); #1;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           rs;
    @(posedge clk); #1;
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_O", 32'(O), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    issue(8'hC8, 8'h3F, 1'b0); wait_done(); idle(1);
    issue(8'hF8, 8'hFA, 1'b1); wait_done();
    issue(8'hCE, 8'h03, 1'b1); wait_done(); idle(1);
    issue(8'h0F, 8'h00, 1'b0); wait_done(); idle(1);
    issue(8'hF6, 8'h00, 1'b1); wait_done(); idle(1);
    issue(8'h80, 8'hFF, 1'b1); wait_done(); idle(1);
    issue(8'h80, 8'h02, 1'b1); wait_done(); idle(1);
    issue(8'h80, 8'h01, 1'b1); wait_done(); idle(1);

    // A second start while busy must be ignored.
    issue(8'hFF, 8'h10, 1'b0);
    idle(1);
    A = 8'h01; B = 8'h01; start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(); idle(3);

    // Asynchronous reset mid-operation aborts with no done.
    issue(8'hC8, 8'h07, 1'b0);
    idle(3);
    reset = 1'b1;
    #1;
    chk("arst_Q", 32'(Q), 32'd0);
    chk("arst_R", 32'(R), 32'd0);
    chk("arst_O", 32'(O), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    sb.delete();
    hold_q = '0; hold_r = '0; hold_o = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(14);
    issue(8'h64, 8'h07, 1'b0); wait_done(); idle(1);

    for (int n = 0; n < 150; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      if ($urandom_range(0, 19) == 0) begin ra = 8'h80; rb = 8'hFF; rs = 1'b1; end
      if ($urandom_range(0, 9) == 0) ra = 8'h80;
      issue(ra, rb, rs);
      wait_done();
      if ($urandom_range(0, 1) == 0) idle(1);
    end

    idle(12);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
